// File: rtl/lm_sm_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : lm_sm_sequencer_if
//  Description : Bundle between the decode stage and the LM/SM sequencer.
//                The master side presents the fetched IR and the pipeline
//                hold/flush controls. The slave side (the sequencer) returns
//                the micro-op controls for the second pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lm_sm_sequencer_if;
    logic [15:0] ir_in;
    logic        hold;
    logic        flush;
    logic        stall_fetch;
    logic        modify_ir;
    logic [2:0]  uop_ra;
    logic        first_multiple;
    logic [2:0]  uop_offset;
    logic [2:0]  base_ra;
    logic        last_uop;
    logic        nop_out;

    // Pipeline / decode side
    modport master (
        output ir_in, hold, flush,
        input  stall_fetch, modify_ir, uop_ra, first_multiple,
               uop_offset, base_ra, last_uop, nop_out
    );

    // Sequencer side
    modport slave (
        input  ir_in, hold, flush,
        output stall_fetch, modify_ir, uop_ra, first_multiple,
               uop_offset, base_ra, last_uop, nop_out
    );
endinterface
`default_nettype wire

// File: rtl/lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lm_sm_sequencer
//  Description : Decode-stage micro-op sequencer for LM/SM. Expands one
//                load/store-multiple instruction into one micro-op per
//                selected register (lowest index first), stalling fetch
//                until the final micro-op. Other opcodes pass through.
//  Revision    : 1.0 - initial release
// ============================================================================
module lm_sm_sequencer (
    input  wire logic         clk,
    input  wire logic         reset,     // asynchronous, active-low
    lm_sm_sequencer_if.slave  bus
);

    localparam logic [3:0] c_OP_LM = 4'b0110;
    localparam logic [3:0] c_OP_SM = 4'b0111;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] mask_q,  mask_d;     // registers still to be issued
    logic [2:0] count_q, count_d;    // micro-ops already emitted
    logic [2:0] base_q,  base_d;     // base register of the sequence

    logic       w_multi;
    logic [7:0] w_list;
    logic [7:0] w_src;               // pending set for the current micro-op
    logic [7:0] w_low;               // one-hot lowest pending bit
    logic [7:0] w_rest;              // pending set after this micro-op
    logic       w_one;               // exactly one register left
    logic [2:0] w_idx;               // index of the lowest pending bit
    logic       w_active;

    // Lowest-set-bit index; scanning downward lets the lowest hit win.
    function automatic logic [2:0] f_low_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Shared decode of the pending register set for this cycle
    always_comb begin
        w_active = (state_q == ST_ACTIVE);
        w_multi  = (bus.ir_in[15:12] == c_OP_LM) || (bus.ir_in[15:12] == c_OP_SM);
        w_list   = bus.ir_in[7:0];
        w_src    = w_active ? mask_q : w_list;
        w_low    = w_src & (~w_src + 8'd1);
        w_rest   = w_src & ~w_low;
        w_one    = (w_src != 8'd0) && (w_rest == 8'd0);
        w_idx    = f_low_index(w_src);
    end

    // Micro-op controls; zero-latency, gated off by reset and flush
    always_comb begin
        bus.stall_fetch    = 1'b0;
        bus.modify_ir      = 1'b0;
        bus.uop_ra         = 3'd0;
        bus.first_multiple = 1'b0;
        bus.uop_offset     = 3'd0;
        bus.base_ra        = 3'd0;
        bus.last_uop       = 1'b0;
        bus.nop_out        = 1'b0;
        if (reset && !bus.flush) begin
            if (w_active) begin
                // Continuing sequence: IR is held by stall_fetch, use latched state
                bus.base_ra = base_q;
                if (mask_q != 8'd0) begin
                    bus.modify_ir   = 1'b1;
                    bus.uop_ra      = w_idx;
                    bus.uop_offset  = count_q;
                    bus.last_uop    = w_one;
                    bus.stall_fetch = !w_one;
                end
            end else begin
                bus.base_ra = bus.ir_in[11:9];
                if (w_multi) begin
                    if (w_list != 8'd0) begin
                        bus.modify_ir      = 1'b1;
                        bus.uop_ra         = w_idx;
                        bus.first_multiple = 1'b1;
                        bus.last_uop       = w_one;
                        bus.stall_fetch    = !w_one;
                    end else begin
                        // Empty register list: squash into a bubble
                        bus.nop_out = 1'b1;
                    end
                end
            end
        end
    end

    // Next-state: flush beats hold, hold freezes, otherwise advance
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        count_d = count_q;
        base_d  = base_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
            mask_d  = 8'd0;
            count_d = 3'd0;
        end else if (!bus.hold) begin
            if (w_active) begin
                count_d = count_q + 3'd1;
                if (w_one || (mask_q == 8'd0)) begin
                    state_d = ST_IDLE;
                    mask_d  = 8'd0;
                end else begin
                    mask_d  = w_rest;
                end
            end else if (w_multi && (w_list != 8'd0) && !w_one) begin
                // First of a multi-register sequence: latch what remains
                state_d = ST_ACTIVE;
                mask_d  = w_rest;
                count_d = 3'd1;
                base_d  = bus.ir_in[11:9];
            end
        end
    end

    // Sequencer state registers with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mask_q  <= 8'd0;
            count_q <= 3'd0;
            base_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            base_q  <= base_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lm_sm_sequencer
//  Description : Directed self-checking bench for lm_sm_sequencer. Each step
//                drives the inputs, queues the expected output word and
//                compares it against the DUT at the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lm_sm_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Expected word: {stall, modify, ra[2:0], first, off[2:0], base[2:0], last, nop}
    logic [13:0] exp_q[$];

    lm_sm_sequencer_if bus ();

    lm_sm_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] ev(input logic st, input logic mo,
                                       input logic [2:0] ra, input logic fm,
                                       input logic [2:0] off, input logic [2:0] b,
                                       input logic la, input logic np);
        return {st, mo, ra, fm, off, b, la, np};
    endfunction

    // One clock cycle: drive, queue expectation, check mid-cycle, advance
    task automatic step(input logic [15:0] ir, input logic h, input logic f,
                        input logic r, input logic [13:0] e, input string tag);
        logic [13:0] obs;
        logic [13:0] want;
        bus.ir_in = ir;
        bus.hold  = h;
        bus.flush = f;
        reset     = r;
        exp_q.push_back(e);
        @(negedge clk);
        obs  = {bus.stall_fetch, bus.modify_ir, bus.uop_ra, bus.first_multiple,
                bus.uop_offset, bus.base_ra, bus.last_uop, bus.nop_out};
        want = exp_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        bus.ir_in = 16'h6425;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        #2;

        // In reset every output is 0 even with LM on ir_in
        step(16'h6425, 0, 0, 0, ev(0,0,0,0,0,0,0,0), "reset_state");

        // LM R2, list 0x25 -> R0, R2, R5
        step(16'h6425, 0, 0, 1, ev(1,1,0,1,0,2,0,0), "lm25_u0");
        step(16'h6425, 0, 0, 1, ev(1,1,2,0,1,2,0,0), "lm25_u1");
        step(16'h6425, 0, 0, 1, ev(0,1,5,0,2,2,1,0), "lm25_u2");
        step(16'h1000, 0, 0, 1, ev(0,0,0,0,0,0,0,0), "pass_1000");
        step(16'h1E00, 0, 0, 1, ev(0,0,0,0,0,7,0,0), "pass_base7");

        // SM R3, single R7
        step(16'h7680, 0, 0, 1, ev(0,1,7,1,0,3,1,0), "sm_single");
        step(16'hF000, 0, 0, 1, ev(0,0,0,0,0,0,0,0), "nop_after_single");

        // Full list, then back-to-back LM
        for (int i = 0; i < 8; i++) begin
            step(16'h64FF, 0, 0, 1,
                 ev(i < 7, 1, 3'(i), i == 0, 3'(i), 2, i == 7, 0), "full_list");
        end
        step(16'h6425, 0, 0, 1, ev(1,1,0,1,0,2,0,0), "b2b_u0");
        step(16'h6425, 0, 0, 1, ev(1,1,2,0,1,2,0,0), "b2b_u1");
        step(16'h6425, 0, 0, 1, ev(0,1,5,0,2,2,1,0), "b2b_u2");

        // Hold for two cycles in the second micro-op
        step(16'h6425, 0, 0, 1, ev(1,1,0,1,0,2,0,0), "hold_u0");
        step(16'h6425, 1, 0, 1, ev(1,1,2,0,1,2,0,0), "hold_h1");
        step(16'h6425, 1, 0, 1, ev(1,1,2,0,1,2,0,0), "hold_h2");
        step(16'h6425, 0, 0, 1, ev(1,1,2,0,1,2,0,0), "hold_u1");
        step(16'h6425, 0, 0, 1, ev(0,1,5,0,2,2,1,0), "hold_u2");

        // Flush mid-sequence, then a fresh LM restarts cleanly
        step(16'h6425, 0, 0, 1, ev(1,1,0,1,0,2,0,0), "flush_u0");
        step(16'h6425, 0, 1, 1, ev(0,0,0,0,0,0,0,0), "flush_cycle");
        step(16'h1000, 0, 0, 1, ev(0,0,0,0,0,0,0,0), "after_flush");
        step(16'h6425, 0, 0, 1, ev(1,1,0,1,0,2,0,0), "refetch_u0");
        step(16'h6425, 0, 0, 1, ev(1,1,2,0,1,2,0,0), "refetch_u1");
        step(16'h6425, 0, 0, 1, ev(0,1,5,0,2,2,1,0), "refetch_u2");

        // Empty register list
        step(16'h6400, 0, 0, 1, ev(0,0,0,0,0,2,0,1), "empty_list");

        // Reset pulsed mid-sequence
        step(16'h6425, 0, 0, 1, ev(1,1,0,1,0,2,0,0), "rst_u0");
        step(16'h6425, 0, 0, 0, ev(0,0,0,0,0,0,0,0), "rst_mid");
        step(16'h6425, 0, 0, 1, ev(1,1,0,1,0,2,0,0), "rst_restart_u0");
        step(16'h6425, 0, 0, 1, ev(1,1,2,0,1,2,0,0), "rst_restart_u1");
        step(16'h6425, 0, 0, 1, ev(0,1,5,0,2,2,1,0), "rst_restart_u2");
        step(16'h0000, 0, 0, 1, ev(0,0,0,0,0,0,0,0), "idle_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Decode-stage micro-op sequencer for LM/SM (load/store multiple). It sits between the first and second pipeline registers: it consumes the fetched IR and expands one LM/SM instruction into one micro-op per selected register. While it does so it stalls fetch and drives the IR-rewrite and first-micro-op controls of the second pipeline register. All other opcodes pass through untouched.

## Interface
- No parameters. Opcode encodings are fixed: LM = 4'b0110, SM = 4'b0111, NOP = 16'hF000.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. 0 clears all state immediately, independent of clk.
- ir_in  input  16  IR output of the first pipeline register.
- hold  input  1  downstream stall (load-use hazard); freezes sequencer state.
- flush  input  1  branch/jump flush; aborts any sequence in progress.
- stall_fetch  output  1  holds the PC and the first pipeline register.
- modify_ir  output  1  second pipeline register replaces IR[11:9] with uop_ra.
- uop_ra  output  3  register index of the current micro-op (modify_pr2_ra).
- first_multiple  output  1  current micro-op is the first of its sequence.
- uop_offset  output  3  count of micro-ops already emitted in this sequence; used for address = base + offset.
- base_ra  output  3  base register IR[11:9] of the sequence, latched at the first micro-op.
- last_uop  output  1  current micro-op is the final one.
- nop_out  output  1  second pipeline register must load NOP (empty register list).

## Operation
- Register list is IR[7:0]; bit i selects register Ri. Registers are issued in ascending index (lowest set bit first).
- State: state ∈ {IDLE, ACTIVE}, mask[7:0] (bits not yet issued), count[2:0], base[2:0].
- Outputs are combinational from (state, mask, count, base, ir_in, flush). All state is registered.
- Definition: `multi = (ir_in[15:12]==LM or SM)`.
- IDLE, multi, list≠0:
  - uop_ra = lowest set bit of IR[7:0]; modify_ir=1, first_multiple=1, uop_offset=0, base_ra=IR[11:9].
  - If exactly one bit is set: last_uop=1, stall_fetch=0, stay IDLE.
  - Otherwise: stall_fetch=1. Next edge: mask ← list with the issued bit cleared, count ← 1, base ← IR[11:9], state ← ACTIVE.
- IDLE, multi, list=0: nop_out=1; modify_ir, first_multiple and stall_fetch are 0; stay IDLE.
- IDLE, not multi: all outputs 0; base_ra=IR[11:9].
- ACTIVE: ir_in is guaranteed to be held by stall_fetch.
  - uop_ra = lowest set bit of mask; modify_ir=1, first_multiple=0, uop_offset=count, base_ra=base.
  - last_uop = (exactly one bit left in mask); stall_fetch = !last_uop.
  - Next edge: clear the issued bit and count ← count+1. If last_uop, state ← IDLE and mask ← 0.
- count is 3-bit. A full list (8'hFF) issues offsets 0..7 and count never wraps within a sequence.
- hold=1: state, mask, count and base keep their values; outputs still reflect the current micro-op and stall_fetch is as computed.
- flush=1 (priority over hold and sequencing): all outputs forced to 0 that cycle. Next edge: state ← IDLE, mask ← 0, count ← 0.
- While reset=0: every output is 0; state=IDLE, mask=0, count=0, base=0.

## Timing
- Zero-cycle latency: micro-op controls are valid in the same cycle ir_in presents LM/SM.
- A list with N set bits occupies exactly N un-held cycles.
  - stall_fetch is high for the first N-1 of them and low in the Nth.
  - Fetch resumes on the edge that ends the last micro-op.
- hold cycles extend the sequence 1:1 and never duplicate or skip a register.
- Reset deasserting mid-stream resumes in IDLE. An LM/SM still present on ir_in restarts from its first register.
- Back-to-back LM/SM: the second instruction is seen in IDLE on the cycle after the first one's last micro-op. It is handled normally with first_multiple=1.

## Test plan
- ir_in=16'h6425 (LM, base R2, list 8'h25) -> three cycles:
  - uop_ra=0,2,5
  - first_multiple=1,0,0
  - uop_offset=0,1,2
  - stall_fetch=1,1,0
  - last_uop=0,0,1
  - base_ra=2 throughout
- ir_in=16'h7680 (SM, base R3, single R7) -> one cycle: uop_ra=7, first_multiple=1, last_uop=1, stall_fetch=0; state stays IDLE.
- ir_in=16'h64FF -> eight cycles: uop_ra=0..7, uop_offset=0..7; stall_fetch=0 only in the 8th; then IDLE with count=0.
- 16'h6425 with hold=1 in the 2nd cycle for 2 cycles -> uop_ra sequence 0,2,2,2,5; stall_fetch high until the cycle with uop_ra=5.
- 16'h6425 with flush=1 in the 2nd cycle -> that cycle all outputs 0; next cycle ir_in=16'h1000 gives all outputs 0 and stall_fetch=0.
- ir_in=16'h6400 -> nop_out=1, stall_fetch=0.
- reset pulsed low mid-sequence of 16'h6425 -> outputs 0 immediately. After release, the sequence restarts at uop_ra=0 with first_multiple=1.
